// File: rtl/moving_average_filter.sv
// moving_average_filter
//   Boxcar average of the last TAPS accepted DW-bit unsigned samples.
//   One averaged output per accepted input, one cycle after acceptance.
//   Synchronous active-low reset_n; synchronous active-high flush.
//
//   Build option:
//     MAVG_ROUND_EN  defined   -> Dout = floor((S + floor(TAPS/2)) / TAPS)  (round half up)
//                    undefined -> Dout = floor(S / TAPS)                    (truncate)
//
//   Before the window has filled, missing history counts as zero, so early
//   averages are biased low. The primed flag tells downstream when the
//   window holds TAPS real samples.

module moving_average_filter #(
  parameter int DW   = 8,
  parameter int TAPS = 3
) (
  input  logic          CLK,
  input  logic          reset_n,
  input  logic          in_valid,
  input  logic [DW-1:0] Din,
  input  logic          flush,
  output logic          out_valid,
  output logic [DW-1:0] Dout,
  output logic          primed
);

  // Running-sum width; TAPS*(2^DW-1) always fits.
  localparam int SW = DW + $clog2(TAPS);
  // Fill-counter width; must be able to hold the value TAPS itself.
  localparam int CW = $clog2(TAPS + 1);
  localparam logic [CW-1:0] TAPS_C = CW'(TAPS);

  logic [DW-1:0] hist [TAPS];
  logic [SW-1:0] sum;
  logic [SW-1:0] sum_next;
  logic [CW-1:0] fill_cnt;
  logic [CW-1:0] fill_next;
  logic          sum_upd;
  logic [DW-1:0] avg;
  logic          accept;

  // Reset and flush both override the handshake; a sample in that cycle is lost.
  assign accept = reset_n && !flush && in_valid;

  // The oldest sample is always already counted in sum, so the subtract cannot underflow.
  assign sum_next = sum + SW'(Din) - SW'(hist[TAPS-1]);

  // Fill counter saturates at TAPS.
  assign fill_next = (fill_cnt == TAPS_C) ? fill_cnt : fill_cnt + CW'(1);

`ifdef MAVG_ROUND_EN
  localparam logic [SW:0] TAPS_V = (SW+1)'(TAPS);
  localparam logic [SW:0] HALF_V = (SW+1)'(TAPS / 2);
  logic [SW:0] sum_rnd;

  // One extra bit so adding the half-divisor cannot wrap at full scale.
  assign sum_rnd = {1'b0, sum} + HALF_V;
  assign avg     = DW'(sum_rnd / TAPS_V);
`else
  localparam logic [SW-1:0] TAPS_V = SW'(TAPS);

  assign avg = DW'(sum / TAPS_V);
`endif

  // Delay line: newest sample enters at index 0, oldest leaves from TAPS-1.
  always_ff @(posedge CLK) begin
    if (!reset_n || flush) begin
      for (int i = 0; i < TAPS; i++) hist[i] <= '0;
    end else if (in_valid) begin
      hist[0] <= Din;
      for (int i = 1; i < TAPS; i++) hist[i] <= hist[i-1];
    end
  end

  // Running sum, fill counter and primed flag advance only on accepted samples.
  always_ff @(posedge CLK) begin
    if (!reset_n || flush) begin
      sum      <= '0;
      fill_cnt <= '0;
      primed   <= 1'b0;
    end else if (accept) begin
      sum      <= sum_next;
      fill_cnt <= fill_next;
      primed   <= (fill_next == TAPS_C);
    end
  end

  // Marks that sum changed on this edge, so the next edge publishes a new average.
  always_ff @(posedge CLK) begin
    if (!reset_n || flush) begin
      sum_upd <= 1'b0;
    end else begin
      sum_upd <= in_valid;
    end
  end

  // Output register: flush cancels an in-flight result but leaves Dout alone; reset zeroes it.
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      Dout      <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= sum_upd;
      if (sum_upd) Dout <= avg;
    end
  end

endmodule

// File: tb/tb_moving_average_filter.sv
// Testbench for moving_average_filter: a TAPS=3 and a TAPS=4 instance share
// one stimulus stream. A queue-based model of the accepted-sample history
// predicts out_valid/Dout/primed for both every cycle; directed sequences
// pin the model with hand-computed literal outputs.

module tb_moving_average_filter;

  logic       CLK;
  logic       reset_n;
  logic       in_valid;
  logic [7:0] Din;
  logic       flush;

  logic       ov3, pr3, ov4, pr4;
  logic [7:0] do3, do4;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 0;

  moving_average_filter #(.DW(8), .TAPS(3)) dut3 (
    .CLK(CLK), .reset_n(reset_n), .in_valid(in_valid), .Din(Din), .flush(flush),
    .out_valid(ov3), .Dout(do3), .primed(pr3)
  );

  moving_average_filter #(.DW(8), .TAPS(4)) dut4 (
    .CLK(CLK), .reset_n(reset_n), .in_valid(in_valid), .Din(Din), .flush(flush),
    .out_valid(ov4), .Dout(do4), .primed(pr4)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int q[$];              // accepted samples since last clear, newest first
  bit pend;              // a sample was accepted on the previous edge
  int pend_avg [2];
  int exp_dout [2];
  bit exp_valid[2];
  bit exp_primed[2];
  int taps_of  [2] = '{3, 4};

  function automatic int mavg(input int t);
    int s = 0;
    for (int i = 0; i < t && i < q.size(); i++) s += q[i];
`ifdef MAVG_ROUND_EN
    return (s + t / 2) / t;
`else
    return s / t;
`endif
  endfunction

  always @(posedge CLK) begin
    if (!reset_n) begin
      q.delete();
      pend = 0;
      for (int k = 0; k < 2; k++) begin
        exp_dout[k] = 0; exp_valid[k] = 0; exp_primed[k] = 0;
      end
    end else if (flush) begin
      q.delete();
      pend = 0;
      for (int k = 0; k < 2; k++) begin
        exp_valid[k] = 0; exp_primed[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        exp_valid[k] = pend;
        if (pend) exp_dout[k] = pend_avg[k];
      end
      pend = in_valid;
      if (in_valid) begin
        q.push_front(int'(Din));
        if (q.size() > 32) void'(q.pop_back());
        for (int k = 0; k < 2; k++) begin
          pend_avg[k]   = mavg(taps_of[k]);
          exp_primed[k] = (q.size() >= taps_of[k]);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    if (check_en) begin
      chk("t3_out_valid", int'(ov3), int'(exp_valid[0]));
      chk("t3_Dout",      int'(do3), exp_dout[0]);
      chk("t3_primed",    int'(pr3), int'(exp_primed[0]));
      chk("t4_out_valid", int'(ov4), int'(exp_valid[1]));
      chk("t4_Dout",      int'(do4), exp_dout[1]);
      chk("t4_primed",    int'(pr4), int'(exp_primed[1]));
    end
  end

  // ---------------- output capture for literal checks ----------------
  int cap3[$];
  int cap4[$];
  int exp_q[$];

  always @(negedge CLK) begin
    if (ov3) cap3.push_back(int'(do3));
    if (ov4) cap4.push_back(int'(do4));
  end

  task automatic set_exp(input int n, input int a, input int b, input int c, input int d);
    exp_q.delete();
    if (n > 0) exp_q.push_back(a);
    if (n > 1) exp_q.push_back(b);
    if (n > 2) exp_q.push_back(c);
    if (n > 3) exp_q.push_back(d);
  endtask

  task automatic cmp_cap(input string nm, input bit use4);
    int got[$];
    got = use4 ? cap4 : cap3;
    chk($sformatf("%s_count", nm), got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_out%0d", nm, i), got[i], exp_q[i]);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit v, input int d, input bit f);
    in_valid = v;
    Din      = d[7:0];
    flush    = f;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc(0, 0, 0);
    reset_n = 1'b1;
    cap3.delete();
    cap4.delete();
  endtask

  initial begin
    int r;
    int d;
    reset_n  = 1'b0;
    in_valid = 1'b1;
    Din      = 8'd200;
    flush    = 1'b0;

    // Reset held 3 cycles with a sample presented
    for (int i = 0; i < 3; i++) begin
      cyc(1, 200, 0);
      check_en = 1;
      chk("rst_Dout",      int'(do3), 0);
      chk("rst_out_valid", int'(ov3), 0);
      chk("rst_primed",    int'(pr3), 0);
    end
    reset_n = 1'b1;
    cap3.delete();
    cap4.delete();

    // Fill and steady state
    cyc(1, 3, 0);
    cyc(1, 6, 0);
    chk("fill_primed_before", int'(pr3), 0);
    cyc(1, 9, 0);
    chk("fill_primed_after", int'(pr3), 1);
    cyc(1, 12, 0);
    repeat (3) cyc(0, 0, 0);
    set_exp(4, 1, 3, 6, 9);
    cmp_cap("fill", 0);

    // Full scale
    do_reset();
    repeat (4) cyc(1, 255, 0);
    repeat (3) cyc(0, 0, 0);
    set_exp(4, 85, 170, 255, 255);
    cmp_cap("fullscale", 0);

    // Gaps
    do_reset();
    cyc(1, 30, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("gap_hold_Dout", int'(do3), 10);
    chk("gap_hold_valid", int'(ov3), 0);
    cyc(1, 60, 0);
    cyc(0, 0, 0);
    cyc(1, 90, 0);
    repeat (3) cyc(0, 0, 0);
    set_exp(3, 10, 30, 60, 0);
    cmp_cap("gaps", 0);

    // Flush drops the coincident sample and cancels the in-flight output
    do_reset();
    repeat (4) cyc(1, 90, 0);
    cyc(1, 90, 1);
    chk("flush_primed",    int'(pr3), 0);
    chk("flush_out_valid", int'(ov3), 0);
    chk("flush_hold_Dout", int'(do3), 90);
    cyc(1, 9, 0);
    repeat (3) cyc(0, 0, 0);
    set_exp(4, 30, 60, 90, 3);
    cmp_cap("flush", 0);

    // Rounding on the TAPS=4 instance
    do_reset();
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    repeat (3) cyc(0, 0, 0);
`ifdef MAVG_ROUND_EN
    set_exp(2, 0, 1, 0, 0);
`else
    set_exp(2, 0, 0, 0, 0);
`endif
    cmp_cap("round_t4", 1);

    // Randomized traffic with occasional flush and reset
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      r = $urandom_range(0, 9);
      d = (r < 2) ? 255 : (r < 3) ? 0 : $urandom_range(0, 255);
      cyc($urandom_range(0, 9) < 7, d, $urandom_range(0, 39) == 0);
    end
    reset_n = 1'b1;
    repeat (4) cyc(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
